// File: rtl/opcode_fold_decoder_pkg.sv
// rtl/opcode_fold_decoder_pkg.sv - shared constants and types for the opcode fold decoder
package opcode_fold_decoder_pkg;

  // BF mnemonic codes in the existing 4-bit encoding
  localparam logic [3:0] OP_INC        = 4'd0;  // +
  localparam logic [3:0] OP_DEC        = 4'd1;  // -
  localparam logic [3:0] OP_LEFT       = 4'd2;  // <
  localparam logic [3:0] OP_RIGHT      = 4'd3;  // >
  localparam logic [3:0] OP_OUT        = 4'd4;  // .
  localparam logic [3:0] OP_IN         = 4'd5;  // ,
  localparam logic [3:0] OP_LOOP_BEGIN = 4'd6;  // [
  localparam logic [3:0] OP_LOOP_END   = 4'd7;  // ]

  // Pointer and cell arithmetic are the only codes worth merging
  localparam logic [15:0] DEFAULT_FOLD_MASK = 16'h000F;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACC   = 2'd1,
    ST_EMIT  = 2'd2
  } fold_state_e;

endpackage

// File: rtl/opcode_fold_decoder_onehot_decoder.sv
// rtl/opcode_fold_decoder_onehot_decoder.sv - combinational code to one-hot decoder
module onehot_decoder #(
  parameter int INSN_WIDTH = 4
) (
  input  logic [INSN_WIDTH-1:0]      code_i,
  output logic [2**INSN_WIDTH-1:0]   onehot_o
);

  // Single bit set at the position named by the code
  always_comb begin
    onehot_o         = '0;
    onehot_o[code_i] = 1'b1;
  end

endmodule

// File: rtl/opcode_fold_decoder.sv
// rtl/opcode_fold_decoder.sv - instruction stream decoder that folds repeated opcodes
module opcode_fold_decoder
  import opcode_fold_decoder_pkg::*;
#(
  parameter int INSN_WIDTH  = 4,
  parameter int COUNT_WIDTH = 4,
  parameter logic [2**INSN_WIDTH-1:0] FOLD_MASK = DEFAULT_FOLD_MASK
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      insn_valid_i,
  output logic                      insn_ready_o,
  input  logic [INSN_WIDTH-1:0]     insn_i,
  input  logic                      flush_i,
  output logic                      op_valid_o,
  input  logic                      op_ready_i,
  output logic [2**INSN_WIDTH-1:0]  opcode_o,
  output logic [COUNT_WIDTH-1:0]    repeat_count_o
);

  localparam int OPCODES = 2**INSN_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] MAXCNT = '1;
  localparam logic [COUNT_WIDTH-1:0] ONE    = COUNT_WIDTH'(1);

  fold_state_e              state_q, state_d;
  logic [INSN_WIDTH-1:0]    held_code_q, held_code_d;
  logic [COUNT_WIDTH-1:0]   held_count_q, held_count_d;
  logic                     held_valid_q, held_valid_d;
  logic [INSN_WIDTH-1:0]    next_code_q, next_code_d;
  logic                     next_valid_q, next_valid_d;
  logic                     op_valid_q, op_valid_d;
  logic                     insn_ready_q, insn_ready_d;

  logic                     accept;
  logic [COUNT_WIDTH-1:0]   count_inc;
  logic [OPCODES-1:0]       held_onehot;

  assign accept    = insn_valid_i && insn_ready_q;
  assign count_inc = held_count_q + ONE;

  // Next-state logic: fold matching codes, park one differing code in next
  always_comb begin
    state_d      = state_q;
    held_code_d  = held_code_q;
    held_count_d = held_count_q;
    held_valid_d = held_valid_q;
    next_code_d  = next_code_q;
    next_valid_d = next_valid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          held_code_d  = insn_i;
          held_count_d = ONE;
          held_valid_d = 1'b1;
          state_d      = (FOLD_MASK[insn_i] && !flush_i) ? ST_ACC : ST_EMIT;
        end
      end
      ST_ACC: begin
        if (accept) begin
          if (insn_i == held_code_q && held_count_q < MAXCNT) begin
            held_count_d = count_inc;
            if (count_inc == MAXCNT) state_d = ST_EMIT;
          end else begin
            next_code_d  = insn_i;
            next_valid_d = 1'b1;
            state_d      = ST_EMIT;
          end
        end
        if (flush_i) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (op_ready_i) begin
          if (next_valid_q) begin
            held_code_d  = next_code_q;
            held_count_d = ONE;
            next_valid_d = 1'b0;
            state_d      = FOLD_MASK[next_code_q] ? ST_ACC : ST_EMIT;
          end else if (accept) begin
            held_code_d  = insn_i;
            held_count_d = ONE;
            state_d      = FOLD_MASK[insn_i] ? ST_ACC : ST_EMIT;
          end else begin
            held_valid_d = 1'b0;
            state_d      = ST_EMPTY;
          end
        end else if (accept) begin
          next_code_d  = insn_i;
          next_valid_d = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    op_valid_d   = (state_d == ST_EMIT);
    insn_ready_d = !((state_d == ST_EMIT) && next_valid_d);
  end

  // State and registered handshake outputs; reset drops any partial fold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_EMPTY;
      held_code_q  <= '0;
      held_count_q <= '0;
      held_valid_q <= 1'b0;
      next_code_q  <= '0;
      next_valid_q <= 1'b0;
      op_valid_q   <= 1'b0;
      insn_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      held_code_q  <= held_code_d;
      held_count_q <= held_count_d;
      held_valid_q <= held_valid_d;
      next_code_q  <= next_code_d;
      next_valid_q <= next_valid_d;
      op_valid_q   <= op_valid_d;
      insn_ready_q <= insn_ready_d;
    end
  end

  onehot_decoder #(
    .INSN_WIDTH(INSN_WIDTH)
  ) u_onehot (
    .code_i   (held_code_q),
    .onehot_o (held_onehot)
  );

  assign op_valid_o     = op_valid_q && held_valid_q;
  assign insn_ready_o   = insn_ready_q;
  assign opcode_o       = held_onehot & {OPCODES{op_valid_o}};
  assign repeat_count_o = op_valid_o ? held_count_q : '0;

endmodule

// File: tb/tb_opcode_fold_decoder.sv
// tb/tb_opcode_fold_decoder.sv - self-checking bench for opcode_fold_decoder
module tb_opcode_fold_decoder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        insn_valid_i = 1'b0;
  logic        insn_ready_o;
  logic [3:0]  insn_i = '0;
  logic        flush_i = 1'b0;
  logic        op_valid_o;
  logic        op_ready_i = 1'b1;
  logic [15:0] opcode_o;
  logic [3:0]  repeat_count_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  opcode_fold_decoder dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .insn_valid_i   (insn_valid_i),
    .insn_ready_o   (insn_ready_o),
    .insn_i         (insn_i),
    .flush_i        (flush_i),
    .op_valid_o     (op_valid_o),
    .op_ready_i     (op_ready_i),
    .opcode_o       (opcode_o),
    .repeat_count_o (repeat_count_o)
  );

  always #5 clk = ~clk;

  // Output monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst_i) begin
      if (op_valid_o && op_ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: opcode=%h count=%0d, required no output", opcode_o, repeat_count_o);
        end else begin
          exp_t e;
          logic [15:0] exp_oh;
          e = exp_q.pop_front();
          exp_oh = 16'h0001 << e.code;
          if (opcode_o !== exp_oh || repeat_count_o !== e.cnt) begin
            bad++;
            $display("FAIL output_match: opcode=%h count=%0d, required opcode=%h count=%0d",
                     opcode_o, repeat_count_o, exp_oh, e.cnt);
          end
        end
      end else if (!op_valid_o) begin
        total++;
        if (opcode_o !== 16'h0 || repeat_count_o !== 4'd0) begin
          bad++;
          $display("FAIL idle_zero: opcode=%h count=%0d, required 0/0", opcode_o, repeat_count_o);
        end
      end
    end
  end

  task automatic send(input logic [3:0] c);
    bit ok = 0;
    insn_i = c;
    insn_valid_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (insn_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: insn_ready=%b, required 1 within 50 cycles", insn_ready_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    insn_valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic pulse_flush();
    insn_valid_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if (op_valid_o !== 1'b0 || opcode_o !== 16'h0 || repeat_count_o !== 4'd0 || insn_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: valid=%b opcode=%h count=%0d ready=%b, required 0/0000/0/1",
               op_valid_o, opcode_o, repeat_count_o, insn_ready_o);
    end
    @(posedge clk);
    #1;
    // Three folds into an open group, then reset discards it
    op_ready_i = 1'b1;
    send(4'd0);
    send(4'd0);
    send(4'd0);
    idle();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if (op_valid_o !== 1'b0 || opcode_o !== 16'h0 || repeat_count_o !== 4'd0 || insn_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_acc: valid=%b opcode=%h count=%0d ready=%b, required 0/0000/0/1",
               op_valid_o, opcode_o, repeat_count_o, insn_ready_o);
    end
    repeat (5) begin
      @(negedge clk);
      total++;
      if (op_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_emit: valid=%b, required 0", op_valid_o);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fold_run();
    op_ready_i = 1'b1;
    exp_q.push_back('{code: 4'd0, cnt: 4'd3});
    exp_q.push_back('{code: 4'd5, cnt: 4'd1});
    send(4'd0);
    send(4'd0);
    send(4'd0);
    send(4'd5);
    idle();
    drain();
  endtask

  task automatic test_saturation();
    op_ready_i = 1'b1;
    exp_q.push_back('{code: 4'd0, cnt: 4'd15});
    exp_q.push_back('{code: 4'd0, cnt: 4'd2});
    for (int i = 0; i < 17; i++) send(4'd0);
    pulse_flush();
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    op_ready_i = 1'b1;
    exp_q.push_back('{code: 4'd8, cnt: 4'd1});
    exp_q.push_back('{code: 4'd8, cnt: 4'd1});
    send(4'd8);
    insn_i = 4'd8;
    insn_valid_i = 1'b1;
    @(negedge clk);
    total++;
    if (op_valid_o !== 1'b1 || opcode_o !== 16'h0100 || insn_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: valid=%b opcode=%h ready=%b, required 1/0100/1", op_valid_o, opcode_o, insn_ready_o);
    end
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    total++;
    if (op_valid_o !== 1'b1 || opcode_o !== 16'h0100 || repeat_count_o !== 4'd1) begin
      bad++;
      $display("FAIL b2b_second: valid=%b opcode=%h count=%0d, required 1/0100/1", op_valid_o, opcode_o, repeat_count_o);
    end
    drain();
  endtask

  task automatic test_backpressure();
    op_ready_i = 1'b0;
    exp_q.push_back('{code: 4'd8, cnt: 4'd1});
    exp_q.push_back('{code: 4'd9, cnt: 4'd1});
    send(4'd8);
    send(4'd9);
    idle();
    repeat (5) begin
      @(negedge clk);
      total++;
      if (insn_ready_o !== 1'b0 || op_valid_o !== 1'b1 || opcode_o !== 16'h0100 || repeat_count_o !== 4'd1) begin
        bad++;
        $display("FAIL backpressure_hold: ready=%b valid=%b opcode=%h count=%0d, required 0/1/0100/1",
                 insn_ready_o, op_valid_o, opcode_o, repeat_count_o);
      end
    end
    @(posedge clk);
    #1;
    op_ready_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (insn_ready_o !== 1'b1 || opcode_o !== 16'h0200) begin
      bad++;
      $display("FAIL backpressure_release: ready=%b opcode=%h, required 1/0200", insn_ready_o, opcode_o);
    end
    drain();
  endtask

  task automatic test_flush();
    op_ready_i = 1'b1;
    exp_q.push_back('{code: 4'd1, cnt: 4'd2});
    send(4'd1);
    send(4'd1);
    idle();
    @(negedge clk);
    total++;
    if (op_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_open: valid=%b, required 0 before flush", op_valid_o);
    end
    @(posedge clk);
    #1;
    pulse_flush();
    @(negedge clk);
    total++;
    if (op_valid_o !== 1'b1 || opcode_o !== 16'h0002 || repeat_count_o !== 4'd2) begin
      bad++;
      $display("FAIL flush_emit: valid=%b opcode=%h count=%0d, required 1/0002/2", op_valid_o, opcode_o, repeat_count_o);
    end
    drain();
    pulse_flush();
    repeat (3) begin
      @(negedge clk);
      total++;
      if (op_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL flush_empty: valid=%b, required 0", op_valid_o);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_fold_run();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
